fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the asynchronous FIFO among `N` requesters in the write clock domain. It grants one requester at a time, holds the grant for a bounded burst, and stalls transfers while the FIFO reports full. It sits directly in front of the FIFO write-side pointer logic: it drives `wrreq` and write data, and consumes the registered full flag.

## Interface

Parameters:

- `N`, 4 — number of requesters (2..8).
- `DW`, 8 — data width.
- `MAX_BURST`, 4 — maximum accepted words per grant (1..15).

Ports:

- `wrclk`  in  1  write-domain clock.
- `rst`  in  1  reset; asynchronous assert, active-low (0 = reset).
- `req`  in  N  per-requester request; level; holds while the requester has data.
- `din`  in  N*DW  flattened data; requester i uses `din[i*DW +: DW]`.
- `full`  in  1  registered FIFO full flag, `wrclk` domain.
- `gnt`  out  N  registered one-hot grant, or all zeros.
- `accept`  out  N  one-hot pulse: the granted requester's word is written this cycle.
- `wrreq`  out  1  FIFO write request.
- `wrdata`  out  DW  FIFO write data.

## Operation

- **State**
  - `gnt` register.
  - Burst counter `cnt`, width `$clog2(MAX_BURST+1)`.
  - Round-robin pointer `last`, the index of the most recent winner.
  - FSM states are IDLE (`gnt` = 0) and BUSY (`gnt` one-hot).
- **Combinational outputs**
  - `accept = gnt & req & {N{~full}}`
  - `wrreq = |accept`
  - `wrdata` = `din` slice selected by `gnt`; 0 when `gnt` = 0.
- **Arbitration function `pick`**
  - Scan candidates from `last+1` upward, modulo N.
  - The first index with `req` set wins.
  - No requester set means no winner.
- **IDLE**
  - If any `req`: load `gnt` = one-hot(`pick`), `last` = winner, `cnt` = 0, go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY: release conditions.** Release when either holds at the edge:
  - (a) the granted `req` is low; or
  - (b) `accept` is high and `cnt+1 == MAX_BURST`.
- **BUSY: on release**
  - Re-arbitrate at the same edge. Candidates are all `req` bits, except the releasing requester in case (a).
  - A winner loads `gnt`, `last` and `cnt` = 0, and the FSM stays in BUSY.
  - No winner sets `gnt` = 0 and returns the FSM to IDLE.
- **BUSY: no release**
  - `cnt` increments on `accept` and holds otherwise.
- **Full**
  - No `accept` and no `wrreq`; `gnt`, `cnt` and `last` hold.
  - Case (a) still releases while full.
- **Fairness**
  - Because `last` is the previous winner, a requester released by burst limit is scanned last.
  - It regains the port immediately only if no other requester is asserting `req`.

## Timing

- **Reset values**
  - `gnt` = 0, FSM = IDLE, `cnt` = 0, `last` = N-1, so requester 0 has first priority.
  - `accept` = 0, `wrreq` = 0, `wrdata` = 0.
- **Latency**
  - Request to grant: 1 cycle from IDLE.
  - Grant to first write: 0 cycles when not full.
  - Back-to-back handover: no bubble cycle.
- **Throughput**
  - One word per cycle while granted, `req` high and not full.
- **Requester handshake**
  - A word is consumed exactly on cycles with `accept[i]` = 1.
  - `din[i]` must hold until accepted.
  - `req` may drop only after the last accepted word. The requester drops `req` in the cycle after its final `accept`.
- **Full**
  - The `full` change takes effect in the same cycle; there is no lookahead.
  - Correctness relies on `full` being registered and conservative on the FIFO write side.
- **Reset mid-burst**
  - `gnt` and `wrreq` drop immediately and asynchronously.
  - The partial burst is abandoned; no further words are written until re-grant.

## Structure

- **Shared package `fifo_pkg`**
  - Arbiter FSM state typedef (IDLE/BUSY).
  - Default `DW`.
  - A function computing the round-robin one-hot `pick` from (`req`, `last`, N).
- **Sub-module `rr_pick`**
  - Combinational rotate / priority-encode / rotate-back, returning winner index and valid.
  - Instantiated once and shared by the IDLE and release paths.
- **Top-level contents**
  - FSM, `cnt`, `last`, output muxing.

## Test plan

- **Reset:** hold `rst` = 0 with all `req` = 1 → `gnt`, `wrreq`, `wrdata` = 0. Release reset → `gnt` = 0001 on the next edge, then `wrreq` = 1.
- **Burst limit:** `req` = 0011 held, `full` = 0, `MAX_BURST` = 4 → the pattern below repeats with no idle cycle.
  - `accept[0]` for 4 cycles.
  - `gnt` = 0010 with `accept[1]` for 4 cycles.
  - `gnt` = 0001 again.
- **Early release:** `req[2]` alone, drops after 2 accepted words while `req[3]` = 1 → `gnt` goes 0100 → 1000 at that edge. Exactly 2 words from requester 2 appear on `wrdata`.
- **Full stall:** `full` = 1 for 5 cycles mid-burst after 2 words → `wrreq` = 0, `gnt` unchanged, `cnt` = 2 held. After `full` falls, exactly 2 more words are written, then handover.
- **Lone requester:** only `req[1]` = 1, `MAX_BURST` = 2 → re-granted to itself at each burst boundary. `wrreq` is continuously 1 with no bubble.
- **Async reset mid-burst:** assert `rst` between edges during a transfer → `wrreq` = 0 before the next edge. Post-reset the first grant goes to the lowest-index active requester.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
package fifo_pkg;

  localparam int DEF_DW = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // Reference round-robin one-hot pick: scan from last+1 upward, modulo n.
  function automatic logic [7:0] rr_pick_onehot(input logic [7:0] req,
                                                input logic [2:0] last,
                                                input int         n);
    logic [7:0] oh;
    int         idx;
    oh = '0;
    for (int k = n; k >= 1; k--) begin
      idx = (int'(last) + k) % n;
      if (req[idx]) oh = 8'(1 << idx);
    end
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate past last, priority-encode, rotate back.
module rr_pick #(
  parameter  int N  = 4,
  localparam int LW = $clog2(N)
) (
  input  logic [N-1:0]  cand,
  input  logic [LW-1:0] last,
  output logic [LW-1:0] idx,
  output logic          vld
);

  localparam logic [LW-1:0] LAST_IDX = LW'(N - 1);
  localparam logic [LW:0]   NV       = (LW + 1)'(N);

  logic [LW-1:0]  w_start;
  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [LW-1:0]  w_off;
  logic [LW:0]    w_sum;

  assign w_start = (last == LAST_IDX) ? '0 : last + LW'(1);
  assign w_dbl   = {cand, cand} >> w_start;
  assign w_rot   = w_dbl[N-1:0];

  always_comb begin
    w_off = '0;
    vld   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = LW'(i);
        vld   = 1'b1;
      end
    end
  end

  assign w_sum = {1'b0, w_start} + {1'b0, w_off};
  assign idx   = (w_sum >= NV) ? LW'(w_sum - NV) : w_sum[LW-1:0];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the async FIFO write port among N requesters.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int N         = 4,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = 4
) (
  input  logic            wrclk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] din,
  input  logic            full,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    accept,
  output logic            wrreq,
  output logic [DW-1:0]   wrdata
);

  localparam int LW = $clog2(N);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_LIM = CW'(MAX_BURST);
  localparam logic [N-1:0]  ONE       = N'(1);

  arb_state_t    r_state;
  logic [N-1:0]  r_gnt;
  logic [CW-1:0] r_cnt;
  logic [LW-1:0] r_last;

  logic [N-1:0]  w_accept;
  logic          w_wrreq;
  logic [DW-1:0] w_wrdata;
  logic          w_gnt_req;
  logic          w_rel_a;
  logic          w_rel;
  logic [CW-1:0] w_cnt_nxt;
  logic [N-1:0]  w_cand;
  logic [LW-1:0] w_win;
  logic          w_win_vld;

  assign w_accept  = r_gnt & req & {N{~full}};
  assign w_wrreq   = |w_accept;
  assign w_gnt_req = |(r_gnt & req);
  assign w_rel_a   = ~w_gnt_req;
  assign w_cnt_nxt = r_cnt + CW'(1);
  assign w_rel     = w_rel_a | (w_wrreq & (w_cnt_nxt == BURST_LIM));

  // A requester that dropped req is excluded from the same-edge re-arbitration.
  assign w_cand = (r_state == ST_BUSY && w_rel_a) ? (req & ~r_gnt) : req;

  rr_pick #(.N(N)) u_pick (
    .cand (w_cand),
    .last (r_last),
    .idx  (w_win),
    .vld  (w_win_vld)
  );

  always_comb begin
    w_wrdata = '0;
    for (int i = 0; i < N; i++) begin
      if (r_gnt[i]) w_wrdata = w_wrdata | din[i*DW +: DW];
    end
  end

  always_ff @(posedge wrclk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_cnt   <= '0;
      r_last  <= LW'(N - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_win_vld) begin
            r_gnt   <= ONE << w_win;
            r_last  <= w_win;
            r_cnt   <= '0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_rel) begin
            if (w_win_vld) begin
              r_gnt  <= ONE << w_win;
              r_last <= w_win;
              r_cnt  <= '0;
            end else begin
              r_gnt   <= '0;
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end
          end else if (w_wrreq) begin
            r_cnt <= w_cnt_nxt;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt    = r_gnt;
  assign accept = w_accept;
  assign wrreq  = w_wrreq;
  assign wrdata = w_wrdata;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed + random stimulus against a behavioural owner/word-count model, two burst limits.
module tb_fifo_wr_arbiter;

  logic        wrclk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din;
  logic        full;

  logic [3:0] gnt0, acc0, gnt1, acc1;
  logic       wrreq0, wrreq1;
  logic [7:0] wd0, wd1;

  int n_vec = 0;
  int n_err = 0;

  // model: index 0 -> MAX_BURST 4, index 1 -> MAX_BURST 2
  int m_owner [2];
  int m_words [2];
  int m_last  [2];
  int m_max   [2] = '{4, 2};
  int words_from2;

  always #5 wrclk = ~wrclk;

  fifo_wr_arbiter #(.N(4), .DW(8), .MAX_BURST(4)) u_dut0 (
    .wrclk(wrclk), .rst(rst), .req(req), .din(din), .full(full),
    .gnt(gnt0), .accept(acc0), .wrreq(wrreq0), .wrdata(wd0));

  fifo_wr_arbiter #(.N(4), .DW(8), .MAX_BURST(2)) u_dut1 (
    .wrclk(wrclk), .rst(rst), .req(req), .din(din), .full(full),
    .gnt(gnt1), .accept(acc1), .wrreq(wrreq1), .wrdata(wd1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] cand, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (cand[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_words[d] = 0;
      m_last[d]  = 3;
    end
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      logic [3:0] eg, ea;
      logic [7:0] ewd;
      eg  = (m_owner[d] >= 0) ? 4'(1 << m_owner[d]) : 4'b0;
      ea  = (m_owner[d] >= 0 && req[m_owner[d]] && !full) ? eg : 4'b0;
      ewd = (m_owner[d] >= 0) ? din[m_owner[d]*8 +: 8] : 8'h00;
      chk($sformatf("gnt%0d", d),    (d == 0) ? gnt0   : gnt1,   eg);
      chk($sformatf("accept%0d", d), (d == 0) ? acc0   : acc1,   ea);
      chk($sformatf("wrreq%0d", d),  (d == 0) ? wrreq0 : wrreq1, |ea);
      chk($sformatf("wrdata%0d", d), (d == 0) ? wd0    : wd1,    ewd);
    end
  endtask

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      int  o, w;
      bit  acc;
      logic [3:0] cand;
      o   = m_owner[d];
      acc = (o >= 0) && req[o] && !full;
      if (o < 0) begin
        w = pick(req, m_last[d]);
        if (w >= 0) begin
          m_owner[d] = w; m_last[d] = w; m_words[d] = 0;
        end
      end else if (!req[o] || (acc && m_words[d] + 1 == m_max[d])) begin
        cand = req;
        if (!req[o]) cand[o] = 1'b0;
        w = pick(cand, m_last[d]);
        if (w >= 0) begin
          m_owner[d] = w; m_last[d] = w; m_words[d] = 0;
        end else begin
          m_owner[d] = -1;
        end
      end else if (acc) begin
        m_words[d]++;
      end
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are checked mid-cycle.
  task automatic step(input logic [3:0] r, input logic f);
    req  = r;
    full = f;
    din  = $urandom;
    #4;
    check_outputs();
    if (acc0[2]) words_from2++;
    model_update();
    @(posedge wrclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    @(posedge wrclk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst  = 1'b0;
    req  = 4'b1111;
    full = 1'b0;
    din  = 32'h44332211;
    model_reset();
    @(posedge wrclk);
    #1;
    // reset held with every requester active
    @(posedge wrclk);
    #4;
    chk("rst_gnt",    gnt0,   4'b0000);
    chk("rst_wrreq",  wrreq0, 1'b0);
    chk("rst_wrdata", wd0,    8'h00);
    chk("rst_gnt1",   gnt1,   4'b0000);
    @(posedge wrclk);
    #1;
    rst = 1'b1;
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    chk("first_gnt", gnt0, 4'b0001);

    // burst limit handover between two requesters
    for (int i = 0; i < 20; i++) step(4'b0011, 1'b0);
    step(4'b0000, 1'b0);

    // early release: requester 2 supplies two words, then 3 takes over
    do_reset();
    words_from2 = 0;
    for (int i = 0; i < 3; i++) step(4'b1100, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b1000, 1'b0);
    chk("early_words2", words_from2, 2);
    step(4'b0000, 1'b0);

    // full stall mid-burst
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b0011, 1'b0);
    for (int i = 0; i < 5; i++) step(4'b0011, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b0011, 1'b0);
    chk("stall_handover", gnt0, 4'b0010);

    // full plus request drop still releases
    step(4'b0001, 1'b1);
    step(4'b0001, 1'b1);
    step(4'b0000, 1'b0);

    // lone requester keeps the port with no bubble
    for (int i = 0; i < 12; i++) step(4'b0010, 1'b0);
    chk("lone_wrreq1", wrreq1, 1'b1);

    // asynchronous reset between edges during a transfer
    for (int i = 0; i < 3; i++) step(4'b0110, 1'b0);
    req = 4'b0110;
    full = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    chk("async_wrreq0", wrreq0, 1'b0);
    chk("async_gnt0",   gnt0,   4'b0000);
    chk("async_wrreq1", wrreq1, 1'b0);
    model_reset();
    @(posedge wrclk);
    #1;
    rst = 1'b1;
    step(4'b0110, 1'b0);
    step(4'b0110, 1'b0);
    chk("post_rst_gnt", gnt0, 4'b0010);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(4'($urandom), ($urandom_range(0, 3) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
